// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the bit-serial operand feeder and comparators.
package serial_cmp_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ser_state_t;

  localparam int DEFAULT_WIDTH = 16;

endpackage : serial_cmp_pkg

// File: rtl/serial_shift_reg.sv
// Parallel-load shift register that emits one bit per shift, MSB or LSB end.
module serial_shift_reg #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  logic [WIDTH-1:0] sh_r;

  // Load wins over shift; zeros fill behind so a fully shifted word leaves the register clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_r <= '0;
    end else if (load) begin
      sh_r <= din;
    end else if (shift) begin
      sh_r <= MSB_FIRST ? {sh_r[WIDTH-2:0], 1'b0} : {1'b0, sh_r[WIDTH-1:1]};
    end else begin
      sh_r <= sh_r;
    end
  end

  assign dout = MSB_FIRST ? sh_r[WIDTH-1] : sh_r[0];

endmodule : serial_shift_reg

// File: rtl/serial_operand_serializer.sv
// Streams WIDTH-bit operand pairs out one bit per clock with first/last framing;
// a one-deep holding register keeps consecutive words gap-free.
module serial_operand_serializer
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_valid,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_t       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0] pend_a_r, pend_b_r;
  logic             pend_valid_r;
  logic             xfer_s, slot_s, load_s, shift_s;
  logic [WIDTH-1:0] ld_a_s, ld_b_s;
  logic             bit_a_s, bit_b_s;

  assign in_ready = ~pend_valid_r;
  assign xfer_s   = in_valid & ~pend_valid_r;
  // The pending word always has priority; in_ready is low whenever it is present.
  assign ld_a_s   = pend_valid_r ? pend_a_r : in_a;
  assign ld_b_s   = pend_valid_r ? pend_b_r : in_b;

  // Next-state, counter and load/shift decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    slot_s      = 1'b0;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    case (state_r)
      IDLE:    slot_s = 1'b1;
      SHIFT:   slot_s = (cnt_r == LAST_CNT);
      default: slot_s = 1'b1;
    endcase
    load_s = slot_s & (pend_valid_r | xfer_s);
    if (load_s) begin
      state_nxt_s = SHIFT;
      cnt_nxt_s   = '0;
    end else if (state_r == SHIFT) begin
      shift_s = 1'b1;
      if (slot_s) begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = '0;
    end
  end

  // FSM state and bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Holding register: filled only by a transfer that cannot load the shifter this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_r <= 1'b0;
      pend_a_r     <= '0;
      pend_b_r     <= '0;
    end else if (load_s && pend_valid_r) begin
      pend_valid_r <= 1'b0;
      pend_a_r     <= pend_a_r;
      pend_b_r     <= pend_b_r;
    end else if (xfer_s && !load_s) begin
      pend_valid_r <= 1'b1;
      pend_a_r     <= in_a;
      pend_b_r     <= in_b;
    end else begin
      pend_valid_r <= pend_valid_r;
      pend_a_r     <= pend_a_r;
      pend_b_r     <= pend_b_r;
    end
  end

  serial_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sh_a (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .shift (shift_s),
    .din   (ld_a_s),
    .dout  (bit_a_s)
  );

  serial_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sh_b (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .shift (shift_s),
    .din   (ld_b_s),
    .dout  (bit_b_s)
  );

  assign ser_valid = (state_r == SHIFT);
  assign ser_a     = ser_valid & bit_a_s;
  assign ser_b     = ser_valid & bit_b_s;
  assign ser_first = ser_valid & (cnt_r == '0);
  assign ser_last  = ser_valid & (cnt_r == LAST_CNT);
  assign busy      = ser_valid | pend_valid_r;

endmodule : serial_operand_serializer

// File: doc/serial_operand_serializer.md
# serial_operand_serializer

Upstream feeder for the bit-serial comparators. It accepts pairs of WIDTH-bit operands over a valid/ready handshake and streams them out one bit per clock, MSB-first or LSB-first. Each word carries first/last framing so the downstream comparator can restart per word. A one-deep holding register lets consecutive words stream with no idle cycle between them.

## Interface
- WIDTH, 16, operand width in bits; must be ≥ 2.
- MSB_FIRST, 1, 1 = most significant bit first; 0 = least significant bit first.

- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept a pair this cycle
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- ser_valid  output  1  ser_a/ser_b carry a valid bit this cycle
- ser_a  output  1  current bit of a
- ser_b  output  1  current bit of b
- ser_first  output  1  current bit is bit 0 of the word; consumer clears its state on it
- ser_last  output  1  current bit is the final bit of the word
- busy  output  1  ser_valid OR pending word held

## Operation
- State: shift register pair (sh_a, sh_b), bit counter cnt (clog2(WIDTH) bits), FSM {IDLE, SHIFT}, holding register (pend_a, pend_b, pend_valid).
- Handshake: a transfer occurs on a rising edge with in_valid & in_ready.
  - in_ready = ~pend_valid; it is purely a function of registers.
  - While in_valid is high and in_ready is low, the producer holds in_a/in_b stable.
- Load condition at an edge: (state == IDLE) or (state == SHIFT and cnt == WIDTH-1).
  - If a load occurs and pend_valid = 1: the shifter loads the pend word and pend_valid clears.
  - If a load occurs, pend_valid = 0, and a transfer occurs: the shifter loads in_a/in_b directly and pend stays empty.
  - If no load occurs and a transfer occurs: the word goes to pend and pend_valid sets.
  - On a load: cnt is set to 0 and state becomes SHIFT.
  - With no load and no word available at the last bit: state becomes IDLE.
- SHIFT: each edge increments cnt and shifts sh_a/sh_b by one position.
  - MSB_FIRST=1: shift left; outputs are bit [WIDTH-1].
  - MSB_FIRST=0: shift right; outputs are bit [0].
- Outputs in SHIFT:
  - ser_valid = 1.
  - ser_first = (cnt == 0).
  - ser_last = (cnt == WIDTH-1).
- Outputs in IDLE: ser_valid, ser_a, ser_b, ser_first and ser_last are all 0.
- Stream is never stalled: once a word starts, its WIDTH bits appear on WIDTH consecutive cycles.

## Timing
- Reset (rst low, asynchronous): state IDLE, cnt 0, pend_valid 0, shift registers 0.
  - Output values: ser_* = 0, busy = 0, in_ready = 1.
  - The producer does not present words while rst is low.
- Latency: a word transferred at edge E into an IDLE block drives its first bit (ser_first = 1) in the cycle after E.
  - Its last bit appears WIDTH-1 cycles later.
- Back-to-back: with a word pending, the cycle after ser_last carries ser_first of the next word, with no gap.
  - Sustained throughput is one word per WIDTH cycles.
- Transfer on the last-bit cycle with pend empty: the word loads directly, with no gap and no use of pend.
- Reset mid-word: the output stream aborts immediately (ser_valid = 0 while rst is low).
  - The pending word is discarded.
  - No partial word resumes after release.
- A second transfer is impossible while pend is full: in_ready = 0 until the next load frees pend.

## Structure
- Package serial_cmp_pkg holds:
  - typedef enum logic {IDLE, SHIFT} ser_state_t;
  - localparam DEFAULT_WIDTH = 16, shared with the comparator benches.
- One natural sub-module: serial_shift_reg (parameters WIDTH, MSB_FIRST).
  - Ports: load, shift, parallel in, serial out.
  - Instantiated twice, once for a and once for b.
- FSM, counter and holding register live in the top module.

## Test plan
- Single word, WIDTH=16, MSB_FIRST=1, a=16'h6482, b=16'h6262, transferred at edge E:
  - from E+1, ser_a = 0110_0100_1000_0010 and ser_b = 0110_0010_0110_0010;
  - ser_first = 1 only on cycle 1, ser_last = 1 only on cycle 16, then IDLE with ser_valid = 0.
- MSB_FIRST=0, a=16'h0001, b=16'h8000:
  - ser_a = 1 on the first bit only;
  - ser_b = 1 on the last bit only.
- Three words offered continuously (in_valid held high):
  - 48 consecutive ser_valid cycles;
  - in_ready low from the second transfer until that word loads;
  - ser_first every 16 cycles, never a gap.
- Pending backpressure: offer word 2 at bit 3 of word 1, then word 3 immediately.
  - in_ready = 0 until the edge at which word 1 sends ser_last (the load edge);
  - word 3 is transferred on the cycle after it.
- rst asserted asynchronously at bit 7 with a word pending:
  - all outputs go to 0 immediately;
  - after release, in_ready = 1, busy = 0, and no ser_valid appears until a new transfer.
- Integration: feed into serial_comparator_most_significant_first with its clear driven by ser_first.
  - For a=16'h6482, b=16'h6262, the comparator reports greater on ser_last.
